// File: rtl/ahb_host_pkg.sv
// Shared types and constants for the AHB host command queue: command record,
// hsize encodings, FSM states and the 1 KB burst-split mask.
package ahb_host_pkg;

   localparam int LEN_W = 4;

   localparam logic [2:0] BYTE = 3'd0;
   localparam logic [2:0] HALF = 3'd1;
   localparam logic [2:0] WORD = 3'd2;

   localparam logic [9:0] KB_BOUNDARY_MASK = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      ISSUE
   } state_t;

   typedef struct packed {
      logic             write;
      logic [2:0]       size;
      logic [31:0]      addr;
      logic [LEN_W-1:0] len;
   } host_cmd_t;

   // A command is legal when its size is at most a word and its start
   // address is aligned to that size.
   function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
      case (size)
         BYTE:    return 1'b1;
         HALF:    return ~addr_lo[0];
         WORD:    return (addr_lo == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/host_q_fifo.sv
// Synchronous FIFO with occupancy count and a registered head word that
// always shows the oldest entry (first-word fall-through).
module host_q_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    count_next
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr_next;
   logic             push_en;
   logic             pop_en;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      push_en     = 1'b0;
      pop_en      = 1'b0;
      rd_ptr_next = rd_ptr;
      count_next  = count;
      push_en     = push && (count != CW'(DEPTH));
      pop_en      = pop && (count != '0);
      if (pop_en) rd_ptr_next = rd_ptr + AW'(1);
      count_next  = count + CW'(push_en) - CW'(pop_en);
   end

   // NOTE: the storage array has no reset; only pointers, count and head are state that must start clean.
   always_ff @(posedge hclk) begin
      if (push_en) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         // The next head is either already stored or is the word landing this cycle.
         if (count_next != '0)
            rdata <= (push_en && (rd_ptr_next == wr_ptr)) ? wdata : mem[rd_ptr_next];
      end
   end

endmodule

// File: rtl/ahb_host_cmd_queue.sv
// Host command queue feeding ahb_master: buffers burst commands and write data,
// issues beats with 1 KB splits, collects read data. Optional beat statistics
// are built when HOST_CMD_Q_STATS_EN is defined.
module ahb_host_cmd_queue
   import ahb_host_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int WD_DEPTH  = 16,
   parameter int RD_DEPTH  = 16
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [2:0]       cmd_size,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wd_valid,
   output logic             wd_ready,
   input  logic [31:0]      wd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             cmd_err,
   output logic             host_read,
   output logic             host_write,
   output logic             host_cont,
   output logic [2:0]       host_size,
   output logic [31:0]      host_addr,
   output logic [31:0]      host_wdata,
   input  logic [31:0]      bus_rdata,
   input  logic             bus_rdone,
   input  logic             bus_wready,
   output logic [15:0]      rd_beat_cnt,
   output logic [15:0]      wr_beat_cnt
);

   localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
   localparam int WD_CW  = $clog2(WD_DEPTH) + 1;
   localparam int RD_CW  = $clog2(RD_DEPTH) + 1;

   host_cmd_t          cmd_in;
   host_cmd_t          cmd_head;
   host_cmd_t          cur;
   state_t             state;
   logic [LEN_W-1:0]   beats_left;
   logic               legal_in;
   logic               cmd_push;
   logic               cmd_pop;
   logic               cmd_avail;
   logic               wd_push;
   logic               wd_pop;
   logic               rsp_push;
   logic               rsp_pop;
   logic               beat_done;
   logic               space_ok;
   logic [31:0]        next_addr;
   logic [31:0]        need;
   logic [31:0]        rd_free;
   logic [CMD_CW-1:0]  cmd_count;
   logic [CMD_CW-1:0]  cmd_count_next;
   logic [WD_CW-1:0]   wd_count;
   logic [WD_CW-1:0]   wd_count_next;
   logic [RD_CW-1:0]   rsp_count;
   logic [RD_CW-1:0]   rsp_count_next;

   always_comb begin
      cmd_in    = '{write: cmd_write, size: cmd_size, addr: cmd_addr, len: cmd_len};
      legal_in  = cmd_legal(cmd_size, cmd_addr[1:0]);
      cmd_push  = cmd_valid && cmd_ready && legal_in;
      wd_push   = wd_valid && wd_ready;
      rsp_pop   = rsp_valid && rsp_ready;
      rsp_push  = host_read && bus_rdone;
      wd_pop    = host_write && bus_wready;
      beat_done = rsp_push || wd_pop;
      cmd_avail = (cmd_count != '0);
      cmd_pop   = cmd_avail && ((state == IDLE) ||
                                ((state == ISSUE) && beat_done && (beats_left == '0)));
      next_addr = host_addr + (32'd1 << host_size);
      // Launch only when every beat of the burst is already covered.
      need      = 32'(cur.len) + 32'd1;
      rd_free   = 32'(RD_DEPTH) - 32'(rsp_count);
      space_ok  = cur.write ? (32'(wd_count) >= need) : (rd_free >= need);
   end

   host_q_fifo #(.WIDTH($bits(host_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .hclk(hclk), .hreset(hreset), .push(cmd_push), .wdata(cmd_in), .pop(cmd_pop),
      .rdata(cmd_head), .count(cmd_count), .count_next(cmd_count_next)
   );

   host_q_fifo #(.WIDTH(32), .DEPTH(WD_DEPTH)) u_wd_fifo (
      .hclk(hclk), .hreset(hreset), .push(wd_push), .wdata(wd_data), .pop(wd_pop),
      .rdata(host_wdata), .count(wd_count), .count_next(wd_count_next)
   );

   host_q_fifo #(.WIDTH(32), .DEPTH(RD_DEPTH)) u_rsp_fifo (
      .hclk(hclk), .hreset(hreset), .push(rsp_push), .wdata(bus_rdata), .pop(rsp_pop),
      .rdata(rsp_data), .count(rsp_count), .count_next(rsp_count_next)
   );

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         cmd_ready <= 1'b0;
         wd_ready  <= 1'b0;
         rsp_valid <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cmd_ready <= (cmd_count_next != CMD_CW'(CMD_DEPTH));
         wd_ready  <= (wd_count_next != WD_CW'(WD_DEPTH));
         rsp_valid <= (rsp_count_next != '0);
         cmd_err   <= cmd_valid && cmd_ready && !legal_in;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state      <= IDLE;
         cur        <= '0;
         beats_left <= '0;
         host_read  <= 1'b0;
         host_write <= 1'b0;
         host_cont  <= 1'b0;
         host_size  <= '0;
         host_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_avail) begin
                  cur   <= cmd_head;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (space_ok) begin
                  host_read  <= !cur.write;
                  host_write <= cur.write;
                  host_cont  <= 1'b0;
                  host_size  <= cur.size;
                  host_addr  <= cur.addr;
                  beats_left <= cur.len;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (beat_done) begin
                  host_addr  <= next_addr;
                  host_cont  <= ((next_addr[9:0] & KB_BOUNDARY_MASK) != 10'd0);
                  beats_left <= beats_left - 1'b1;
                  if (beats_left == '0) begin
                     host_read  <= 1'b0;
                     host_write <= 1'b0;
                     host_cont  <= 1'b0;
                     if (cmd_avail) begin
                        cur   <= cmd_head;
                        state <= CHECK;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HOST_CMD_Q_STATS_EN
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         rd_beat_cnt <= '0;
         wr_beat_cnt <= '0;
      end else begin
         if (rsp_push && (rd_beat_cnt != 16'hFFFF)) rd_beat_cnt <= rd_beat_cnt + 16'd1;
         if (wd_pop && (wr_beat_cnt != 16'hFFFF)) wr_beat_cnt <= wr_beat_cnt + 16'd1;
      end
   end
`else
   assign rd_beat_cnt = '0;
   assign wr_beat_cnt = '0;
`endif

endmodule
